fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupling buffer between the instruction fetch stage and decode.
- Each cycle it accepts one fetch bundle of two packets from fetch, each packet being {pc, data, taken_branch}.
- It presents up to two oldest packets to decode, which dequeues 0, 1 or 2 per cycle.
- A flush discards all buffered packets in one cycle, so a fetch redirect never leaks stale instructions into decode.

Parameters:
- PACKET_SIZE, 64, width in bits of one fetched packet, treated as opaque.
- DEPTH, 8, number of packet entries. Must be a power of two and at least 4.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_i  in  1  fetch bundle valid.
- data_i  in  2*PACKET_SIZE  bundle; [PACKET_SIZE-1:0] is the older packet (lane a), upper half is the younger (lane b).
- ready_o  out  1  queue can accept a full bundle; drives the fetch ready input.
- flush_i  in  1  discard all entries (must_flush, invalid_prediction or invalid_instruction from downstream).
- data_o  out  2*PACKET_SIZE  {entry[head+1], entry[head]}.
- valid_o  out  2  per-lane valid; bit0 = oldest entry.
- deq_i  in  2  number of packets decode consumes this cycle (0..2).
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State:
  - head and tail pointers, $clog2(DEPTH) bits each; wrap modulo DEPTH by natural overflow.
  - count register, $clog2(DEPTH)+1 bits.
  - storage array entry[DEPTH], not reset.
- Reset (rst=1, asynchronous): head=0, tail=0, count=0. Hence valid_o=2'b00, ready_o=1, data_o=0, count_o=0.
- ready_o = (count <= DEPTH-2), computed from the registered count only. There is no same-cycle dequeue credit, so there is no combinational path from deq_i to ready_o.
- Enqueue fires when valid_i & ready_o & ~flush_i:
  - entry[tail] <= data_i lane a;
  - entry[tail+1] <= data_i lane b;
  - tail <= tail+2.
  - Bundles are always written whole; partial enqueue is not supported.
- Output lanes:
  - valid_o[0] = (count>=1); valid_o[1] = (count>=2).
  - A lane of data_o is forced to 0 when its valid bit is low.
  - valid_o[1] is never 1 while valid_o[0] is 0.
- Dequeue:
  - effective deq = min(deq_i, count); requests beyond valid entries are ignored.
  - head <= head + effective deq.
- Count update: count <= count + (enq ? 2 : 0) - effective deq. Simultaneous enqueue and dequeue is legal in every state.
- Latency: a bundle accepted in cycle N is visible on data_o/valid_o in cycle N+1, with no bypass.
- Flush (flush_i=1): overrides enqueue and dequeue in the same cycle. Next cycle head=tail=0, count=0, ready_o=1. An incoming bundle in that cycle is dropped.
- Full: count=DEPTH gives ready_o=0. Fetch holds its bundle, since fetch valid may stay high and is not dropped.
- count=DEPTH-1 is reachable only through odd dequeues. ready_o=0 in this state.
- Wrap-around: pointer arithmetic wraps silently. Lane b of data_o reads entry[(head+1) mod DEPTH].
- Reset asserted mid-operation: immediate return to the reset state. Data held in storage is ignored afterwards.

Optional Feature:
- Macro FETCH_QUEUE_STATS_EN.
- When defined:
  - Adds output max_count_o, width $clog2(DEPTH)+1: the high-water mark of count since reset. It is updated the cycle after count rises above it. It is cleared only by rst, not by flush_i.
  - Adds output stall_cycles_o, 32 bits: increments each cycle with valid_i & ~ready_o & ~flush_i and saturates at 0xFFFFFFFF. It is cleared only by rst.
- When undefined: neither port nor its registers exist, and the functional behaviour above is unchanged.

Test Plan:
- Reset then idle: rst pulse, valid_i=0 -> valid_o=00, ready_o=1, count_o=0, data_o=0.
- Fill to full (DEPTH=8): four consecutive bundles with deq_i=0 -> count 2,4,6,8. ready_o=1 through count 6 and 0 at count 8. A fifth bundle held high is not written; count stays 8.
- Odd dequeue alignment: enqueue bundle {B,A}, next cycle deq_i=1 -> data_o lane a=B, valid_o=01, count=1. Enqueue {D,C} with deq_i=2 that same cycle -> effective deq 1, count=2, lanes {D,C}.
- Simultaneous enq/deq at count 6: valid_i=1, deq_i=2 -> accepted, count stays 6. Order preserved across pointer wrap after 10 bundles: packets emerge in PC order with no duplicates.
- Flush with concurrent enqueue: count=5, valid_i=1, deq_i=1, flush_i=1 -> next cycle count=0, valid_o=00, ready_o=1, and the bundle is dropped.
- Async reset mid-stream: rst raised between edges at count=4 -> valid_o=00 and count_o=0 before the next clk edge. With FETCH_QUEUE_STATS_EN defined, max_count_o=0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue handshake bundle.
// master: fetch/decode side, slave: the queue.
interface fetch_queue_if #(
  parameter int PACKET_SIZE = 64,
  parameter int DEPTH       = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     valid_i;
  logic [2*PACKET_SIZE-1:0] data_i;
  logic                     ready_o;
  logic                     flush_i;
  logic [2*PACKET_SIZE-1:0] data_o;
  logic [1:0]               valid_o;
  logic [1:0]               deq_i;
  logic [CW-1:0]            count_o;

  modport master (
    output valid_i, data_i, flush_i, deq_i,
    input  ready_o, data_o, valid_o, count_o
  );

  modport slave (
    input  valid_i, data_i, flush_i, deq_i,
    output ready_o, data_o, valid_o, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Two-wide fetch queue between fetch and decode.
// FETCH_QUEUE_STATS_EN adds high-water mark and stall counters.
module fetch_queue #(
  parameter int PACKET_SIZE = 64,
  parameter int DEPTH       = 8
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.slave fq
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [$clog2(DEPTH):0] max_count_o,
  output logic [31:0]            stall_cycles_o
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PACKET_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic [CW-1:0]          count;
  logic [PW-1:0]          head_p1;
  logic [PW-1:0]          tail_p1;
  logic [CW-1:0]          deq_w;
  logic [CW-1:0]          deq_eff;
  logic [CW-1:0]          count_nxt;
  logic                   ready;
  logic                   enq;

  assign ready   = count <= CW'(DEPTH - 2);
  assign enq     = fq.valid_i & ready & ~fq.flush_i;
  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);
  assign deq_w   = CW'(fq.deq_i);

  // Requests beyond the live entries are ignored.
  always_comb begin
    deq_eff   = deq_w;
    if (deq_w > count)
      deq_eff = count;
    count_nxt = count + (enq ? CW'(2) : '0) - deq_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (fq.flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + deq_eff[PW-1:0];
      if (enq)
        tail <= tail + PW'(2);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail]    <= fq.data_i[PACKET_SIZE-1:0];
      mem[tail_p1] <= fq.data_i[2*PACKET_SIZE-1:PACKET_SIZE];
    end
  end

  assign fq.ready_o    = ready;
  assign fq.count_o    = count;
  assign fq.valid_o[0] = count >= CW'(1);
  assign fq.valid_o[1] = count >= CW'(2);
  assign fq.data_o     = {
    fq.valid_o[1] ? mem[head_p1] : '0,
    fq.valid_o[0] ? mem[head]    : '0
  };

`ifdef FETCH_QUEUE_STATS_EN
  logic [CW-1:0] max_q;
  logic [31:0]   stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q   <= '0;
      stall_q <= '0;
    end else begin
      if (count > max_q)
        max_q <= count;
      if (fq.valid_i & ~ready & ~fq.flush_i & ~&stall_q)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign max_count_o    = max_q;
  assign stall_cycles_o = stall_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue.
// Stimulus pushes expected packets/counts; a negedge monitor checks them.
module tb_fetch_queue;
  localparam int PS = 64;
  localparam int DP = 8;

  logic clk;
  logic rst;

  fetch_queue_if #(.PACKET_SIZE(PS), .DEPTH(DP)) fq ();

`ifdef FETCH_QUEUE_STATS_EN
  logic [3:0]  max_count;
  logic [31:0] stall_cycles;
`endif

  fetch_queue #(.PACKET_SIZE(PS), .DEPTH(DP)) dut (
    .clk(clk),
    .rst(rst),
    .fq(fq)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .max_count_o(max_count),
    .stall_cycles_o(stall_cycles)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [PS-1:0] pkt_q [$];
  int            cnt_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PS-1:0] pkt(input int n);
    return 64'hF00D_0000_0000_0000 + 64'(n * 4);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    fq.valid_i = 1'b0;
    fq.data_i  = '0;
    fq.deq_i   = 2'd0;
    fq.flush_i = 1'b0;
  endtask

  // One cycle of stimulus: bundle {pkt(n+1), pkt(n)}.
  task automatic step(input bit v, input int n, input int deq,
                      input bit fl, input bit acc, input int cnt);
    fq.valid_i = v;
    fq.data_i  = v ? {pkt(n + 1), pkt(n)} : '0;
    fq.deq_i   = 2'(deq);
    fq.flush_i = fl;
    if (acc) begin
      pkt_q.push_back(pkt(n));
      pkt_q.push_back(pkt(n + 1));
    end
    @(posedge clk);
    #1;
    cnt_q.push_back(cnt);
  endtask

  // Monitor: checks state produced by the last edge, then retires
  // the lanes decode consumes in the coming edge.
  always @(negedge clk) begin
    int            mcnt;
    int            n;
    logic [PS-1:0] la;
    logic [PS-1:0] lb;
    if (rst) begin
      pkt_q.delete();
      cnt_q.delete();
    end else if (cnt_q.size() > 0) begin
      mcnt = cnt_q.pop_front();
      la   = '0;
      lb   = '0;
      if (mcnt >= 1) la = (pkt_q.size() > 0) ? pkt_q[0] : 'x;
      if (mcnt >= 2) lb = (pkt_q.size() > 1) ? pkt_q[1] : 'x;
      chk("count", 128'(fq.count_o), 128'(mcnt));
      chk("ready", 128'(fq.ready_o), 128'(mcnt <= DP - 2));
      chk("valid", 128'(fq.valid_o), 128'({mcnt >= 2, mcnt >= 1}));
      chk("lane_a", 128'(fq.data_o[PS-1:0]), 128'(la));
      chk("lane_b", 128'(fq.data_o[2*PS-1:PS]), 128'(lb));
      if (fq.flush_i) begin
        pkt_q.delete();
      end else begin
        n = int'(fq.deq_i);
        if (n > mcnt) n = mcnt;
        repeat (n) if (pkt_q.size() > 0) void'(pkt_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(fq.valid_o), 128'(0));
    chk("rst_ready", 128'(fq.ready_o), 128'(1));
    chk("rst_count", 128'(fq.count_o), 128'(0));
    chk("rst_data", fq.data_o, 128'(0));
    rst = 1'b0;

    step(0, 0, 0, 0, 0, 0);
    // fill to full, then hold a bundle against backpressure
    step(1, 0, 0, 0, 1, 2);
    step(1, 2, 0, 0, 1, 4);
    step(1, 4, 0, 0, 1, 6);
    step(1, 6, 0, 0, 1, 8);
    step(1, 8, 0, 0, 0, 8);
    step(1, 8, 0, 0, 0, 8);
    step(0, 0, 2, 0, 0, 6);
    step(0, 0, 2, 0, 0, 4);
    step(0, 0, 2, 0, 0, 2);
    step(0, 0, 2, 0, 0, 0);
    // odd dequeue, then over-request
    step(1, 10, 0, 0, 1, 2);
    step(0, 0, 1, 0, 0, 1);
    step(1, 12, 2, 0, 1, 2);
    // steady enq+deq at count 6 across several wraps
    step(1, 14, 0, 0, 1, 4);
    step(1, 16, 0, 0, 1, 6);
    step(1, 18, 2, 0, 1, 6);
    for (int i = 0; i < 10; i++)
      step(1, 20 + 2 * i, 2, 0, 1, 6);
    step(0, 0, 2, 0, 0, 4);
    step(0, 0, 1, 0, 0, 3);
    step(0, 0, 2, 0, 0, 1);
    step(0, 0, 2, 0, 0, 0);
    // flush at count 5 with concurrent enq/deq
    step(1, 40, 0, 0, 1, 2);
    step(1, 42, 0, 0, 1, 4);
    step(1, 44, 1, 0, 1, 5);
    step(1, 46, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 48, 0, 0, 1, 2);
    step(1, 50, 1, 0, 1, 3);
    step(0, 0, 1, 0, 0, 2);
    step(0, 0, 0, 0, 0, 2);
    step(1, 52, 0, 0, 1, 4);

    // asynchronous reset between edges
    idle();
    chk("pre_rst_count", 128'(fq.count_o), 128'(4));
`ifdef FETCH_QUEUE_STATS_EN
    chk("max_count", 128'(max_count), 128'(8));
    chk("stall_cycles", 128'(stall_cycles), 128'(2));
`endif
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(fq.valid_o), 128'(0));
    chk("arst_count", 128'(fq.count_o), 128'(0));
    chk("arst_ready", 128'(fq.ready_o), 128'(1));
    chk("arst_data", fq.data_o, 128'(0));
`ifdef FETCH_QUEUE_STATS_EN
    chk("arst_max", 128'(max_count), 128'(0));
    chk("arst_stall", 128'(stall_cycles), 128'(0));
`endif
    @(negedge clk);
    #1;
    rst = 1'b0;

    step(0, 0, 0, 0, 0, 0);
    step(1, 60, 0, 0, 1, 2);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 2, 0, 0, 0);
    idle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
